// File: rtl/lab3_pkg.sv
// Shared definitions for the lab3 sequential carry-lookahead datapath.
package lab3_pkg;

  // Bits handled per cycle; tied to the 4-bit lookahead generator.
  localparam int SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lab3_seq_cla_adder_cla.sv
// 4-bit carry-lookahead generator: carries C[4:1] from slice P/G and C0.
module lab3_seq_cla_adder_cla
  import lab3_pkg::*;
(
  input  logic [SLICE-1:0] p_i,
  input  logic [SLICE-1:0] g_i,
  input  logic             c0_i,
  output logic [SLICE:1]   c_o
);

  // Flattened lookahead equations, no ripple between bit positions.
  always_comb begin
    c_o[1] = g_i[0] | (p_i[0] & c0_i);
    c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c0_i);
    c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
           | (p_i[2] & p_i[1] & p_i[0] & c0_i);
    c_o[4] = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
           | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
           | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & c0_i);
  end

endmodule

// File: rtl/lab3_seq_cla_adder.sv
// Multi-cycle adder/subtractor: one 4-bit lookahead slice per cycle,
// operands in and result out through valid/ready handshakes.
module lab3_seq_cla_adder
  import lab3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int NSL  = WIDTH / SLICE;
  localparam int IDXW = $clog2(NSL);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              v_q, v_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  logic [SLICE-1:0]  p, g;
  logic [SLICE:1]    c;

  // Latched operands shift right each cycle, so the active slice is always the low nibble.
  assign p = a_q[SLICE-1:0] ^ b_q[SLICE-1:0];
  assign g = a_q[SLICE-1:0] & b_q[SLICE-1:0];

  lab3_seq_cla_adder_cla u_cla (
    .p_i  (p),
    .g_i  (g),
    .c0_i (carry_q),
    .c_o  (c)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    v_d     = v_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = Sub ? ~B : B;
          carry_d = Sub ? 1'b1 : Cin;
          idx_d   = '0;
          s_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[int'(idx_q)*SLICE +: SLICE] = p ^ {c[SLICE-1:1], carry_q};
        carry_d = c[SLICE];
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        if (idx_q == IDXW'(NSL-1)) begin
          cout_d  = c[SLICE];
          v_d     = c[SLICE] ^ c[SLICE-1];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign Cout      = cout_q;
  assign V         = v_q;

endmodule
